// File: rtl/classificador_digito.sv
// Digit classifier: sweeps the 121 pixel differences of each of ten templates,
// keeps the lowest per-digit score and reports the winning digit or "no match".
module classificador_digito #(
    parameter logic [14:0] LIMIAR = 15'd20000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  diff_in,
    output logic [3:0]  sel_digito,
    output logic [3:0]  sel_linha,
    output logic [3:0]  sel_coluna,
    output logic        ocupado,
    output logic        valido,
    output logic [3:0]  digito,
    output logic [14:0] pontuacao
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [14:0] acc_r;
    logic [14:0] min_r;
    logic [3:0]  best_r;
    logic [14:0] total_s;
    logic [14:0] min_s;
    logic [3:0]  best_s;
    logic        end_col_s;
    logic        end_dig_s;
    logic        last_s;

    // Next state plus the running-minimum update that includes the pixel being sampled now
    always_comb begin
        state_s   = state_r;
        total_s   = acc_r + {7'd0, diff_in};
        end_col_s = (state_r == SCAN) && (sel_coluna == 4'd10);
        end_dig_s = end_col_s && (sel_linha == 4'd10);
        last_s    = end_dig_s && (sel_digito == 4'd9);
        min_s     = min_r;
        best_s    = best_r;
        if (end_dig_s && (total_s < min_r)) begin
            min_s  = total_s;
            best_s = sel_digito;
        end else begin
            min_s  = min_r;
            best_s = best_r;
        end
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SCAN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, pixel walk, score accumulation and registered result outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            sel_digito <= 4'd0;
            sel_linha  <= 4'd0;
            sel_coluna <= 4'd0;
            acc_r      <= 15'd0;
            min_r      <= 15'h7FFF;
            best_r     <= 4'd0;
            ocupado    <= 1'b0;
            valido     <= 1'b0;
            digito     <= 4'hF;
            pontuacao  <= 15'h7FFF;
        end else begin
            state_r <= state_s;
            ocupado <= (state_s == SCAN);
            valido  <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    sel_digito <= 4'd0;
                    sel_linha  <= 4'd0;
                    sel_coluna <= 4'd0;
                    if (start) begin
                        acc_r  <= 15'd0;
                        min_r  <= 15'h7FFF;
                        best_r <= 4'd0;
                    end
                end
                SCAN: begin
                    min_r  <= min_s;
                    best_r <= best_s;
                    acc_r  <= end_dig_s ? 15'd0 : total_s;
                    if (end_col_s) begin
                        sel_coluna <= 4'd0;
                        if (end_dig_s) begin
                            sel_linha  <= 4'd0;
                            sel_digito <= last_s ? 4'd0 : sel_digito + 4'd1;
                        end else begin
                            sel_linha <= sel_linha + 4'd1;
                        end
                    end else begin
                        sel_coluna <= sel_coluna + 4'd1;
                    end
                    // Result is published on the same edge that samples the last pixel
                    if (last_s) begin
                        pontuacao <= min_s;
                        digito    <= (min_s <= LIMIAR) ? best_s : 4'hF;
                    end
                end
                DONE: begin
                    sel_digito <= 4'd0;
                    sel_linha  <= 4'd0;
                    sel_coluna <= 4'd0;
                end
                default: begin
                    sel_digito <= 4'd0;
                    sel_linha  <= 4'd0;
                    sel_coluna <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_classificador_digito.sv
// Scoreboard bench for classificador_digito: a behavioural mux model feeds
// diff_in from the selectors, and expected results are queued per sweep.
module tb_classificador_digito;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        start2;
    logic [7:0]  diff_in;
    logic [7:0]  diff2;
    logic [3:0]  sel_digito, sel_linha, sel_coluna;
    logic [3:0]  sel_digito2, sel_linha2, sel_coluna2;
    logic        ocupado, valido, ocupado2, valido2;
    logic [3:0]  digito, digito2;
    logic [14:0] pontuacao, pontuacao2;
    int          mode;
    int          vectors;
    int          miscompares;

    typedef struct {
        logic [3:0]  d;
        logic [14:0] p;
    } exp_t;
    exp_t sb_q[$];

    classificador_digito u_dut (
        .clock(clock), .reset_n(reset_n), .start(start), .diff_in(diff_in),
        .sel_digito(sel_digito), .sel_linha(sel_linha), .sel_coluna(sel_coluna),
        .ocupado(ocupado), .valido(valido), .digito(digito), .pontuacao(pontuacao)
    );

    classificador_digito #(.LIMIAR(15'd30855)) u_dut_hi (
        .clock(clock), .reset_n(reset_n), .start(start2), .diff_in(diff2),
        .sel_digito(sel_digito2), .sel_linha(sel_linha2), .sel_coluna(sel_coluna2),
        .ocupado(ocupado2), .valido(valido2), .digito(digito2), .pontuacao(pontuacao2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] mux_f(input int m, input logic [3:0] d);
        case (m)
            0:       return 8'd0;
            1:       return (d == 4'd6) ? 8'd0 : 8'd1;
            2:       return 8'd255;
            3:       return (d == 4'd3) ? 8'd100 : ((d == 4'd8) ? 8'd50 : 8'd200);
            default: return 8'd0;
        endcase
    endfunction

    always_comb begin
        diff_in = mux_f(mode, sel_digito);
        diff2   = mux_f(mode, sel_digito2);
    end

    task automatic run_sweep(input string name, input logic [3:0] exp_d,
                             input logic [14:0] exp_p, input bit check_walk,
                             input bit inject);
        exp_t e;
        int   k;
        int   walk_err;
        int   extra;
        k = 0;
        walk_err = 0;
        sb_q.push_back('{d: exp_d, p: exp_p});
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        while (valido !== 1'b1 && k < 1300) begin
            if (k < 1210) begin
                if (sel_digito !== 4'(k / 121) || sel_linha !== 4'((k % 121) / 11) ||
                    sel_coluna !== 4'(k % 11) || ocupado !== 1'b1)
                    walk_err++;
            end
            @(negedge clock);
            k++;
            start = (inject && k == 5);
        end
        start = 1'b0;
        e = sb_q.pop_front();
        vectors++;
        if (k !== 1210) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles, expected 1210", name, k);
        end
        if (check_walk) begin
            vectors++;
            if (walk_err !== 0) begin
                miscompares++;
                $display("FAIL %s selector walk: %0d bad cycles, expected 0", name, walk_err);
            end
        end
        vectors++;
        if (ocupado !== 1'b0) begin
            miscompares++;
            $display("FAIL %s ocupado at valido: got %b, expected 0", name, ocupado);
        end
        vectors++;
        if (digito !== e.d) begin
            miscompares++;
            $display("FAIL %s digito: got %h, expected %h", name, digito, e.d);
        end
        vectors++;
        if (pontuacao !== e.p) begin
            miscompares++;
            $display("FAIL %s pontuacao: got %0d, expected %0d", name, pontuacao, e.p);
        end
        if (inject) start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        vectors++;
        if (valido !== 1'b0) begin
            miscompares++;
            $display("FAIL %s valido width: got %b after one cycle, expected 0", name, valido);
        end
        if (inject) begin
            extra = 0;
            for (int i = 0; i < 1250; i++) begin
                @(negedge clock);
                if (valido === 1'b1 || ocupado === 1'b1) extra++;
            end
            vectors++;
            if (extra !== 0) begin
                miscompares++;
                $display("FAIL %s ignored start: %0d busy/valid cycles, expected 0", name, extra);
            end
            vectors++;
            if (digito !== e.d || pontuacao !== e.p) begin
                miscompares++;
                $display("FAIL %s result hold: got %h/%0d, expected %h/%0d",
                         name, digito, pontuacao, e.d, e.p);
            end
        end
    endtask

    task automatic check_reset_values(input string name);
        vectors++;
        if (ocupado !== 1'b0 || valido !== 1'b0 || digito !== 4'hF || pontuacao !== 15'h7FFF ||
            sel_digito !== 4'd0 || sel_linha !== 4'd0 || sel_coluna !== 4'd0) begin
            miscompares++;
            $display("FAIL %s: got ocupado=%b valido=%b digito=%h pontuacao=%h sel=%0d/%0d/%0d, expected 0 0 f 7fff 0/0/0",
                     name, ocupado, valido, digito, pontuacao, sel_digito, sel_linha, sel_coluna);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_values("reset");
        reset_n = 1'b1;
        @(negedge clock);
        check_reset_values("after reset release");
    endtask

    task automatic test_all_zero();
        mode = 0;
        run_sweep("all_zero", 4'd0, 15'd0, 1'b0, 1'b0);
    endtask

    task automatic test_digit6_walk();
        mode = 1;
        run_sweep("digit6", 4'd6, 15'd0, 1'b1, 1'b0);
    endtask

    task automatic test_saturated_reject();
        mode = 2;
        run_sweep("all_255", 4'hF, 15'd30855, 1'b0, 1'b0);
    endtask

    task automatic test_high_threshold();
        exp_t e;
        int   k;
        mode = 2;
        k = 0;
        sb_q.push_back('{d: 4'd0, p: 15'd30855});
        start2 = 1'b1;
        @(negedge clock);
        start2 = 1'b0;
        while (valido2 !== 1'b1 && k < 1300) begin
            @(negedge clock);
            k++;
        end
        e = sb_q.pop_front();
        vectors++;
        if (k !== 1210 || digito2 !== e.d || pontuacao2 !== e.p) begin
            miscompares++;
            $display("FAIL limiar_30855: got %0d cycles digito=%h pontuacao=%0d, expected 1210 %h %0d",
                     k, digito2, pontuacao2, e.d, e.p);
        end
        @(negedge clock);
    endtask

    task automatic test_mixed();
        mode = 3;
        run_sweep("mixed", 4'd8, 15'd6050, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        mode = 1;
        run_sweep("start_ignored", 4'd6, 15'd0, 1'b0, 1'b1);
        mode = 0;
        run_sweep("restart_idle", 4'd0, 15'd0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        int bad;
        mode = 3;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (600) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async reset mid-sweep");
        @(negedge clock);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 1300; i++) begin
            @(negedge clock);
            if (valido === 1'b1 || ocupado === 1'b1) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL aborted sweep: %0d busy/valid cycles, expected 0", bad);
        end
        run_sweep("after_abort", 4'd8, 15'd6050, 1'b0, 1'b0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        mode = 0;
        start = 1'b0;
        start2 = 1'b0;
        reset_n = 1'b0;
        test_reset();
        test_all_zero();
        test_digit6_walk();
        test_saturated_reject();
        test_high_threshold();
        test_mixed();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
